if_id_stage: RTL and testbench

//  Fetch-side pipeline front end: PC register, next-PC select, IF/ID pipeline register.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/next_pc_mux.sv | 34 +++
 rtl/if_id_stage.sv | 124 ++++++++++++
 tb/tb_if_id_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: PC source encodings, fetch FSM state type, nop encoding.
// No logic, no latency; pure declarations imported by the IF/ID stage and its next-PC mux.
// No flow control here; stall semantics live in if_id_stage.
package mips_pkg;

  // PCSrc_ID encodings as resolved by the ID stage
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  // All-zero word decodes as sll $0,$0,0, i.e. a nop
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_BUBBLE = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC select: sequential PC+PC_INC or one of the ID-resolved redirect targets.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the selected PC is loaded.
// Ports: pc_src (PCSrc encoding), pc (current fetch PC), branch/jump/jr targets,
//        seq_pc (pc+PC_INC, modulo 2^DATA_WIDTH), next_pc (selected next fetch PC).
module next_pc_mux
  import mips_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned PC_INC     = 4
) (
  input  logic [1:0]            pc_src,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic [DATA_WIDTH-1:0] jump_target,
  input  logic [DATA_WIDTH-1:0] jr_target,
  output logic [DATA_WIDTH-1:0] seq_pc,
  output logic [DATA_WIDTH-1:0] next_pc
);

  // Wraps silently at all-ones; targets are taken as given, no alignment forced
  assign seq_pc = pc + DATA_WIDTH'(PC_INC);

  always_comb begin
    next_pc = seq_pc;
    case (pc_src)
      PCSRC_BR: next_pc = branch_target;
      PCSRC_J:  next_pc = jump_target;
      PCSRC_JR: next_pc = jr_target;
      default:  next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch front end: PC register, next-PC select and IF/ID pipeline register with bubble insertion.
// Latency: instruction at PC_IF appears in ID one clock later; an accepted redirect costs one bubble.
// Backpressure: Stall_IF holds the PC, Stall_ID holds IF/ID; a redirect seen during any stall is ignored.
// Ports: clk, reset (sync, active-high); Stall_IF/Stall_ID from the hazard unit; PCSrc_ID and
//        Branch/Jump/JrTarget_ID from ID; Instruction_IF from the ROM at PC_IF; outputs PC_IF,
//        PC4_ID, Instruction_ID, Valid_ID. With IF_ID_PERF_CNT_EN defined, adds saturating
//        StallCycles (cycles with Stall_ID) and FlushCount (accepted redirects).
module if_id_stage
  import mips_pkg::*;
#(
  parameter int                   DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = DATA_WIDTH'(32'h0040_0000),
  parameter int unsigned          PC_INC     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall_IF,
  input  logic                  Stall_ID,
  input  logic [1:0]            PCSrc_ID,
  input  logic [DATA_WIDTH-1:0] BranchTarget_ID,
  input  logic [DATA_WIDTH-1:0] JumpTarget_ID,
  input  logic [DATA_WIDTH-1:0] JrTarget_ID,
  input  logic [DATA_WIDTH-1:0] Instruction_IF,
  output logic [DATA_WIDTH-1:0] PC_IF,
  output logic [DATA_WIDTH-1:0] PC4_ID,
  output logic [DATA_WIDTH-1:0] Instruction_ID,
  output logic                  Valid_ID
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]           StallCycles,
  output logic [31:0]           FlushCount
`endif
);

  fetch_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] seq_pc;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  pc_en;
  logic                  id_en;
  logic                  id_bubble;
  logic                  take_redirect;

  next_pc_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .PC_INC     (PC_INC)
  ) u_next_pc_mux (
    .pc_src        (PCSrc_ID),
    .pc            (PC_IF),
    .branch_target (BranchTarget_ID),
    .jump_target   (JumpTarget_ID),
    .jr_target     (JrTarget_ID),
    .seq_pc        (seq_pc),
    .next_pc       (next_pc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_BOOT;
    else       state_q <= state_d;
  end

  // Next state: RUN, HOLD and BUBBLE all leave by the same stall/redirect rules
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      default: begin
        if (Stall_ID)           state_d = ST_HOLD;
        else if (take_redirect) state_d = ST_BUBBLE;
        else                    state_d = ST_RUN;
      end
    endcase
  end

  // Datapath controls. Stall_ID alone is not a legal hazard-unit output, but it
  // must still freeze the PC or the instruction held in ID would be skipped.
  always_comb begin
    pc_en         = 1'b0;
    id_en         = 1'b0;
    id_bubble     = 1'b0;
    take_redirect = 1'b0;
    pc_en         = !(Stall_IF || Stall_ID);
    id_en         = !Stall_ID;
    take_redirect = !Stall_IF && !Stall_ID && (PCSrc_ID != PCSRC_SEQ);
    // Stall_IF-only starves ID; a redirect flushes the wrong-path fetch
    id_bubble     = Stall_IF || take_redirect;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PC_IF          <= RESET_PC;
      PC4_ID         <= '0;
      Instruction_ID <= DATA_WIDTH'(NOP_INSTR);
      Valid_ID       <= 1'b0;
    end else begin
      if (pc_en) PC_IF <= next_pc;
      if (id_en) begin
        if (id_bubble) begin
          PC4_ID         <= '0;
          Instruction_ID <= DATA_WIDTH'(NOP_INSTR);
          Valid_ID       <= 1'b0;
        end else begin
          PC4_ID         <= seq_pc;
          Instruction_ID <= Instruction_IF;
          Valid_ID       <= 1'b1;
        end
      end
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (Stall_ID && (StallCycles != 32'hFFFF_FFFF))     StallCycles <= StallCycles + 32'd1;
      if (take_redirect && (FlushCount != 32'hFFFF_FFFF)) FlushCount  <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall_IF, Stall_ID;
  logic [1:0]  PCSrc_ID;
  logic [31:0] BranchTarget_ID, JumpTarget_ID, JrTarget_ID, Instruction_IF;
  logic [31:0] PC_IF, PC4_ID, Instruction_ID;
  logic        Valid_ID;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what the fetch stage should hold after each clock
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid;
  logic [31:0] m_stalls, m_flushes;

  if_id_stage dut (
    .clk             (clk),
    .reset           (reset),
    .Stall_IF        (Stall_IF),
    .Stall_ID        (Stall_ID),
    .PCSrc_ID        (PCSrc_ID),
    .BranchTarget_ID (BranchTarget_ID),
    .JumpTarget_ID   (JumpTarget_ID),
    .JrTarget_ID     (JrTarget_ID),
    .Instruction_IF  (Instruction_IF),
    .PC_IF           (PC_IF),
    .PC4_ID          (PC4_ID),
    .Instruction_ID  (Instruction_ID),
    .Valid_ID        (Valid_ID)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .StallCycles     (StallCycles),
    .FlushCount      (FlushCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".PC_IF"}, PC_IF, m_pc);
    chk({tag, ".PC4_ID"}, PC4_ID, m_pc4);
    chk({tag, ".Instruction_ID"}, Instruction_ID, m_instr);
    chk({tag, ".Valid_ID"}, {31'd0, Valid_ID}, {31'd0, m_valid});
`ifdef IF_ID_PERF_CNT_EN
    chk({tag, ".StallCycles"}, StallCycles, m_stalls);
    chk({tag, ".FlushCount"}, FlushCount, m_flushes);
`endif
  endtask

  task automatic drive(input logic rst, input logic sif, input logic sid, input logic [1:0] src,
                       input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt);
    reset           = rst;
    Stall_IF        = sif;
    Stall_ID        = sid;
    PCSrc_ID        = src;
    BranchTarget_ID = bt;
    JumpTarget_ID   = jt;
    JrTarget_ID     = jrt;
    Instruction_IF  = $urandom;
  endtask

  // Reference update from the spec's priority rules: reset > stall > redirect > sequential
  task automatic model_step();
    logic [31:0] tgt;
    if (reset) begin
      m_pc = 32'h0040_0000; m_pc4 = 0; m_instr = 0; m_valid = 0;
      m_stalls = 0; m_flushes = 0;
    end else begin
      if (Stall_ID && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
      if (Stall_ID) begin
        // everything frozen
      end else if (Stall_IF) begin
        m_pc4 = 0; m_instr = 0; m_valid = 0;
      end else if (PCSrc_ID != 2'b00) begin
        tgt = (PCSrc_ID == 2'b01) ? BranchTarget_ID :
              (PCSrc_ID == 2'b10) ? JumpTarget_ID : JrTarget_ID;
        m_pc = tgt; m_pc4 = 0; m_instr = 0; m_valid = 0;
        if (m_flushes != 32'hFFFF_FFFF) m_flushes = m_flushes + 1;
      end else begin
        m_pc4 = m_pc + 32'd4; m_instr = Instruction_IF; m_valid = 1; m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  initial begin
    m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0; m_stalls = 0; m_flushes = 0;

    // Reset
    drive(1, 0, 0, 2'b00, 0, 0, 0);
    tick("reset0");
    tick("reset1");
    chk("reset_pc_const", PC_IF, 32'h0040_0000);

    // Free run: PC 00400000 -> 04 -> 08, Valid 0 -> 1 -> 1
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    tick("free1");
    chk("free1_pc4_const", PC4_ID, 32'h0040_0004);
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    tick("free2");
    chk("free2_pc_const", PC_IF, 32'h0040_0008);

    // Full stall for two cycles: nothing moves
    drive(0, 1, 1, 2'b00, 0, 0, 0);
    tick("stall1");
    drive(0, 1, 1, 2'b00, 0, 0, 0);
    tick("stall2");
    chk("stall_pc_const", PC_IF, 32'h0040_0008);

    // Branch redirect: one bubble, then fetch resumes at target
    drive(0, 0, 0, 2'b01, 32'h0040_0040, 32'h1234_5678, 32'h8765_4320);
    tick("branch");
    chk("branch_pc_const", PC_IF, 32'h0040_0040);
    chk("branch_bubble_const", {31'd0, Valid_ID}, 32'd0);
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    tick("after_branch");

    // JR under stall is ignored, taken once re-presented without stall
    drive(0, 1, 1, 2'b11, 0, 0, 32'h0040_0100);
    tick("jr_stalled");
    drive(0, 0, 0, 2'b11, 0, 0, 32'h0040_0100);
    tick("jr_taken");
    chk("jr_pc_const", PC_IF, 32'h0040_0100);

    // Jump, then wrap at all-ones
    drive(0, 0, 0, 2'b10, 0, 32'h0040_0200, 0);
    tick("jump");
    drive(0, 0, 0, 2'b11, 0, 0, 32'hFFFF_FFFC);
    tick("jr_top");
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    tick("wrap");
    chk("wrap_pc_const", PC_IF, 32'h0000_0000);

    // Stall_IF alone: bubble into ID; Stall_ID alone: all frozen
    drive(0, 1, 0, 2'b01, 32'h0000_0100, 0, 0);
    tick("stall_if_only");
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    tick("seq_again");
    drive(0, 0, 1, 2'b00, 0, 0, 0);
    tick("stall_id_only");

`ifdef IF_ID_PERF_CNT_EN
    drive(1, 0, 0, 2'b00, 0, 0, 0);
    tick("perf_reset");
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 2'b00, 0, 0, 0);
      tick("perf_stall");
    end
    drive(0, 0, 0, 2'b01, 32'h0040_0080, 0, 0);
    tick("perf_br");
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    tick("perf_seq");
    drive(0, 0, 0, 2'b10, 0, 32'h0040_0400, 0);
    tick("perf_j");
    chk("perf_stall_const", StallCycles, 32'd5);
    chk("perf_flush_const", FlushCount, 32'd2);
    drive(1, 1, 1, 2'b01, 0, 0, 0);
    tick("perf_clear");
    chk("perf_stall_clr", StallCycles, 32'd0);
    chk("perf_flush_clr", FlushCount, 32'd0);
`endif

    // Randomized traffic, including reset landing mid-stall or mid-bubble
    for (int i = 0; i < 500; i++) begin
      logic sif, sid;
      logic [1:0] src;
      sif = ($urandom_range(0, 3) == 0);
      sid = sif ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      src = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      drive(($urandom_range(0, 60) == 0), sif, sid, src, $urandom, $urandom, $urandom);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
